hc_event_rx: RTL and testbench
==============================

# hc_event_rx

Receive-side decoder for the hysteresis comparator output. It watches the comparator's 1-bit decision alongside the two signed 8-bit samples. Each level change that holds for `HOLD` consecutive cycles is confirmed as a crossover event, stamped with a free-running cycle counter and the sample difference, and queued in a small FIFO. Downstream logic drains the FIFO over a valid/ready handshake. The block sits directly after the comparator, ahead of any logging or control logic.

## Interface
Parameters:
- `HOLD`, 4, consecutive cycles a new level must persist to be confirmed; legal range 1..255.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `TSW`, 16, timestamp width in bits.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `cmp_in`  in  1  comparator decision: 1 means ts1 exceeds ts2 beyond the threshold.
- `ts1`, `ts2`  in  8 each, signed  samples feeding the comparator.
- `ev_valid`  out  1  FIFO head holds an event.
- `ev_ready`  in  1  consumer accepts the head this cycle.
- `ev_dir`  out  1  1 = rising (0→1), 0 = falling (1→0).
- `ev_time`  out  TSW  timestamp of the first cycle of the confirmed run.
- `ev_diff`  out  9, signed  ts1−ts2 captured on the confirmation edge.
- `ovf`  out  1  sticky; set when an event is dropped because the FIFO is full.

## Operation
- **Reset** (`rst`=0 on an edge):
  - All outputs read 0 and the FIFO is empty.
  - FSM goes to LOW; hold counter 0; timestamp counter 0.
  - Takes priority over every other action.
- **Timestamp counter:**
  - `tstamp` increments by 1 every non-reset edge.
  - It wraps from 2^TSW−1 to 0 with no flag.
- **Filter FSM states:** LOW, PEND_H, HIGH, PEND_L.
  - LOW, `cmp_in`=1: latch `tstamp` as the start time, set hold count to 1, go to PEND_H.
  - PEND_H, `cmp_in`=0: return to LOW, discard, no event.
  - PEND_H, `cmp_in`=1: increment the count. When the count reaches `HOLD`, go to HIGH and push an event with `ev_dir`=1.
  - HIGH and PEND_L mirror LOW and PEND_H with polarity inverted; a confirmed fall pushes `ev_dir`=0.
  - With `HOLD`=1, LOW→HIGH (or HIGH→LOW) is direct and pushes on the same edge the change is first sampled.
  - In LOW or HIGH, a `cmp_in` equal to the confirmed level does nothing.
- **Difference:** `ev_diff` = sign-extended ts1 − sign-extended ts2, in 9 bits, never saturates, range −255..+255.
- **FIFO:**
  - Push on the confirmation edge.
  - Pop when `ev_valid` && `ev_ready`.
  - `ev_valid` = not empty. Head fields are stable while `ev_valid` && !`ev_ready`.
- **Full with simultaneous pop:** the push is accepted, occupancy is unchanged, and `ovf` is not set.
- **Full without pop:** the new event is discarded, `ovf` goes to 1, and the existing contents are untouched.
- `ovf` clears only on reset.
- `ev_ready` while empty is ignored.

## Timing
- First 1 sampled on edge k with `tstamp`=T:
  - The confirmation edge is k+HOLD−1.
  - `ev_valid` is high in the cycle after the confirmation edge, with `ev_time`=T.
- Pop latency: the head advances on the handshake edge; the next entry (if any) is visible the following cycle.
- One event maximum per edge; the FSM cannot confirm a rise and a fall on the same edge.
- Reset mid-pending or mid-drain:
  - Pending runs are lost and no event is emitted.
  - `ev_valid` is 0 in the cycle after the reset edge.
- The first edge after reset release samples `tstamp`=0.

## Test plan
- **Rise, HOLD=4:** release reset; hold `cmp_in`=1 from edge 10 with ts1=20, ts2=5.
  - `ev_valid` rises after edge 13.
  - `ev_dir`=1, `ev_time`=10, `ev_diff`=+15.
- **Glitch rejection, HOLD=4:** `cmp_in` 1 for 3 edges, then 0.
  - No event and state LOW.
  - A following 4-cycle high confirms with `ev_time` equal to the start of the new run.
- **Fall and extremes:** after a confirmed HIGH, drive 0 for 4 edges with ts1=−128, ts2=127.
  - `ev_dir`=0, `ev_diff`=−255.
- **Overflow, DEPTH=4, `ev_ready`=0:** generate 5 confirmed events.
  - 4 events queued, `ovf`=1.
  - Draining yields the first 4 in order.
  - Repeat with the 5th push coinciding with a pop: no drop, `ovf` stays 0.
- **Backpressure:** toggle `ev_ready` pseudo-randomly across 50 events.
  - Head fields never change while stalled.
  - Order and count are preserved.
- **Reset and wrap:**
  - Assert `rst`=0 during PEND_H with 2 events queued: FIFO empty and no event afterwards.
  - TSW=4 run past 15: `ev_time` wraps 15→0 correctly.

Source files
------------

// File: rtl/hc_event_rx.sv
// Crossover event receiver: debounces the comparator decision with a HOLD-cycle filter,
// stamps each confirmed level change and queues it for a valid/ready consumer.
module hc_event_rx #(
    parameter int HOLD  = 4,
    parameter int DEPTH = 4,
    parameter int TSW   = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmp_in,
    input  logic [7:0]     ts1,
    input  logic [7:0]     ts2,
    output logic           ev_valid,
    input  logic           ev_ready,
    output logic           ev_dir,
    output logic [TSW-1:0] ev_time,
    output logic [8:0]     ev_diff,
    output logic           ovf,
    output logic [1:0]     dbg_state_o
);
    // Handshake: an entry transfers on any rising edge where ev_valid && ev_ready;
    // head fields stay stable while ev_valid is high and ev_ready is low.

    localparam logic [1:0] LOW    = 2'd0;
    localparam logic [1:0] PEND_H = 2'd1;
    localparam logic [1:0] HIGH   = 2'd2;
    localparam logic [1:0] PEND_L = 2'd3;

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 1 + TSW + 9;

    logic [1:0]     state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [TSW-1:0] start_q, start_d;
    logic [TSW-1:0] tstamp_q;

    logic           push;
    logic           push_dir;
    logic [TSW-1:0] push_time;
    logic [8:0]     diff;

    logic [EW-1:0]  mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q, count_d;
    logic           ovf_q;
    logic           full, pop, accept;

    assign diff = {ts1[7], ts1} - {ts2[7], ts2};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_d   = start_q;
        push      = 1'b0;
        push_dir  = 1'b0;
        push_time = start_q;
        case (state_q)
            LOW, HIGH: begin
                // A level different from the confirmed one opens a pending run.
                if (cmp_in != (state_q == HIGH)) begin
                    if (HOLD == 1) begin
                        state_d   = (state_q == LOW) ? HIGH : LOW;
                        push      = 1'b1;
                        push_dir  = cmp_in;
                        push_time = tstamp_q;
                    end else begin
                        state_d = (state_q == LOW) ? PEND_H : PEND_L;
                        cnt_d   = 8'd1;
                        start_d = tstamp_q;
                    end
                end
            end
            default: begin
                if (cmp_in != (state_q == PEND_H)) begin
                    state_d = (state_q == PEND_H) ? LOW : HIGH;
                    cnt_d   = 8'd0;
                end else if (cnt_q + 8'd1 == 8'(HOLD)) begin
                    state_d  = (state_q == PEND_H) ? HIGH : LOW;
                    cnt_d    = 8'd0;
                    push     = 1'b1;
                    push_dir = (state_q == PEND_H);
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase
    end

    assign full   = (count_q == (AW+1)'(DEPTH));
    assign pop    = ev_valid && ev_ready;
    // When full, a same-edge pop frees the slot the write pointer already points at.
    assign accept = push && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (accept && !pop)      count_d = count_q + 1'b1;
        else if (pop && !accept) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= LOW;
            cnt_q    <= 8'd0;
            start_q  <= '0;
            tstamp_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            tstamp_q <= tstamp_q + 1'b1;
            count_q  <= count_d;
            if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && full && !pop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && accept) mem_q[wr_ptr_q] <= {push_dir, push_time, diff};
    end

    // Head fields are gated so every output reads 0 while the queue is empty.
    assign ev_valid    = (count_q != '0);
    assign ev_dir      = ev_valid ? mem_q[rd_ptr_q][EW-1]       : 1'b0;
    assign ev_time     = ev_valid ? mem_q[rd_ptr_q][EW-2 -: TSW] : '0;
    assign ev_diff     = ev_valid ? mem_q[rd_ptr_q][8:0]         : 9'd0;
    assign ovf         = ovf_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_hc_event_rx.sv
// Directed bench for hc_event_rx: main instance (HOLD=4, DEPTH=4, TSW=16) and a
// HOLD=1, TSW=4 instance for direct confirmation and timestamp wrap.
module tb_hc_event_rx;
  localparam int HOLD = 4;

  logic        clk;
  logic        rst, cmp_in, ev_ready;
  logic [7:0]  ts1, ts2;
  logic        ev_valid, ev_dir, ovf;
  logic [15:0] ev_time;
  logic [8:0]  ev_diff;
  logic [1:0]  dbg_state;

  logic        rst2, cmp2, ev_ready2;
  logic        ev_valid2, ev_dir2, ovf2;
  logic [3:0]  ev_time2;
  logic [8:0]  ev_diff2;
  logic [1:0]  dbg_state2;

  logic [25:0] head;
  logic [25:0] exp_q[$];
  logic [15:0] t_now;
  logic [3:0]  t2;
  logic        lvl;
  logic        sb_on;
  int          n_pass, n_total, popped;

  assign head = {ev_dir, ev_time, ev_diff};

  hc_event_rx #(.HOLD(HOLD), .DEPTH(4), .TSW(16)) dut (
    .clk(clk), .rst(rst), .cmp_in(cmp_in), .ts1(ts1), .ts2(ts2),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_dir(ev_dir), .ev_time(ev_time),
    .ev_diff(ev_diff), .ovf(ovf), .dbg_state_o(dbg_state)
  );

  hc_event_rx #(.HOLD(1), .DEPTH(4), .TSW(4)) dut2 (
    .clk(clk), .rst(rst2), .cmp_in(cmp2), .ts1(ts1), .ts2(ts2),
    .ev_valid(ev_valid2), .ev_ready(ev_ready2), .ev_dir(ev_dir2), .ev_time(ev_time2),
    .ev_diff(ev_diff2), .ovf(ovf2), .dbg_state_o(dbg_state2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One edge; t_now/t2 model the timestamp sampled on the next edge.
  task automatic tick();
    logic r, r2, v, rd;
    logic [25:0] h, e;
    r = rst; r2 = rst2; v = ev_valid; rd = ev_ready; h = head;
    @(posedge clk); #1;
    t_now = r ? t_now + 16'd1 : 16'd0;
    t2    = r2 ? t2 + 4'd1 : 4'd0;
    if (sb_on) begin
      if (v && rd) begin
        n_total++;
        popped++;
        if (exp_q.size() == 0) begin
          $display("FAIL bp_pop: got %h, want no entry", h);
        end else begin
          e = exp_q.pop_front();
          if (h !== e) $display("FAIL bp_pop: got %h, want %h", h, e);
          else n_pass++;
        end
      end else if (v) begin
        n_total++;
        if (!ev_valid || head !== h)
          $display("FAIL bp_stall: got v=%0b %h, want v=1 %h", ev_valid, head, h);
        else n_pass++;
      end
    end
  endtask

  // Drives the opposite of the confirmed level for HOLD edges and records the event.
  task automatic make_event(input logic [7:0] a, input logic [7:0] b, input logic rdy_last);
    int ai, bi;
    logic [8:0] d;
    ai = int'($signed(a));
    bi = int'($signed(b));
    d  = 9'(ai - bi);
    exp_q.push_back({~lvl, t_now, d});
    cmp_in = ~lvl; ts1 = a; ts2 = b;
    for (int i = 0; i < HOLD; i++) begin
      if (sb_on) ev_ready = (i == HOLD-1) ? 1'b1 : 1'($urandom_range(0, 1));
      else if (i == HOLD-1) ev_ready = rdy_last;
      tick();
    end
    lvl = ~lvl;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    n_total++;
    if ({ev_valid, ev_dir, ev_time, ev_diff, ovf, dbg_state} !== 30'd0)
      $display("FAIL reset_outputs: got v=%0b d=%0b t=%0d diff=%h ovf=%0b st=%0d, want all 0",
               ev_valid, ev_dir, ev_time, ev_diff, ovf, dbg_state);
    else n_pass++;
    rst = 1'b1;
    lvl = 1'b0;
  endtask

  task automatic test_rise();
    for (int i = 0; i < 10; i++) tick();
    cmp_in = 1'b1; ts1 = 8'd20; ts2 = 8'd5;
    tick(); tick(); tick();
    n_total++;
    if (ev_valid !== 1'b0) $display("FAIL rise_early: got v=%0b, want 0", ev_valid);
    else n_pass++;
    tick();
    n_total++;
    if (ev_valid !== 1'b1 || ev_dir !== 1'b1 || ev_time !== 16'd10 || ev_diff !== 9'd15)
      $display("FAIL rise_event: got v=%0b d=%0b t=%0d diff=%0d, want v=1 d=1 t=10 diff=15",
               ev_valid, ev_dir, ev_time, ev_diff);
    else n_pass++;
    lvl = 1'b1;
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    n_total++;
    if (ev_valid !== 1'b0) $display("FAIL rise_pop: got v=%0b, want 0", ev_valid);
    else n_pass++;
  endtask

  task automatic test_fall();
    logic [25:0] e;
    make_event(8'h80, 8'h7F, 1'b0);
    e = exp_q.pop_front();
    n_total++;
    if (ev_valid !== 1'b1 || ev_dir !== 1'b0 || ev_diff !== 9'h101 || ev_time !== e[24:9])
      $display("FAIL fall_event: got v=%0b d=%0b t=%0d diff=%h, want v=1 d=0 t=%0d diff=101",
               ev_valid, ev_dir, ev_time, ev_diff, e[24:9]);
    else n_pass++;
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
  endtask

  task automatic test_glitch();
    logic [25:0] e;
    cmp_in = 1'b1;
    tick(); tick(); tick();
    cmp_in = 1'b0;
    tick();
    n_total++;
    if (dbg_state !== 2'd0 || ev_valid !== 1'b0)
      $display("FAIL glitch_reject: got st=%0d v=%0b, want st=0 v=0", dbg_state, ev_valid);
    else n_pass++;
    make_event(8'd3, 8'd9, 1'b0);
    e = exp_q.pop_front();
    n_total++;
    if (ev_valid !== 1'b1 || head !== e)
      $display("FAIL glitch_next: got v=%0b %h, want v=1 %h", ev_valid, head, e);
    else n_pass++;
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) make_event(8'(i * 37), 8'(200 - i * 11), 1'b0);
    n_total++;
    if (ovf !== 1'b0) $display("FAIL ovf_at_full: got %0b, want 0", ovf);
    else n_pass++;
    make_event(8'd1, 8'd2, 1'b0);
    n_total++;
    if (ovf !== 1'b1) $display("FAIL ovf_set: got %0b, want 1", ovf);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (ev_valid !== 1'b1 || head !== exp_q[i])
        $display("FAIL ovf_drain%0d: got v=%0b %h, want v=1 %h", i, ev_valid, head, exp_q[i]);
      else n_pass++;
      ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    end
    n_total++;
    if (ev_valid !== 1'b0 || ovf !== 1'b1)
      $display("FAIL ovf_empty: got v=%0b ovf=%0b, want v=0 ovf=1", ev_valid, ovf);
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_reset_midpend();
    make_event(8'd10, 8'd0, 1'b0);
    make_event(8'd0, 8'd10, 1'b0);
    cmp_in = 1'b1;
    tick(); tick();
    n_total++;
    if (dbg_state !== 2'd1 || ev_valid !== 1'b1)
      $display("FAIL pend_before_rst: got st=%0d v=%0b, want st=1 v=1", dbg_state, ev_valid);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_total++;
    if (ev_valid !== 1'b0 || ovf !== 1'b0 || dbg_state !== 2'd0 || ev_time !== 16'd0)
      $display("FAIL rst_mid: got v=%0b ovf=%0b st=%0d t=%0d, want all 0",
               ev_valid, ovf, dbg_state, ev_time);
    else n_pass++;
    rst = 1'b1; cmp_in = 1'b0; lvl = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) tick();
    n_total++;
    if (ev_valid !== 1'b0) $display("FAIL rst_no_event: got v=%0b, want 0", ev_valid);
    else n_pass++;
  endtask

  task automatic test_full_pop();
    ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) make_event(8'(50 + i), 8'(i), 1'b0);
    make_event(8'hF0, 8'h10, 1'b1);
    ev_ready = 1'b0;
    void'(exp_q.pop_front());
    n_total++;
    if (ovf !== 1'b0 || ev_valid !== 1'b1)
      $display("FAIL fullpop_ovf: got ovf=%0b v=%0b, want ovf=0 v=1", ovf, ev_valid);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (ev_valid !== 1'b1 || head !== exp_q[i])
        $display("FAIL fullpop_drain%0d: got v=%0b %h, want v=1 %h", i, ev_valid, head, exp_q[i]);
      else n_pass++;
      ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    end
    n_total++;
    if (ev_valid !== 1'b0) $display("FAIL fullpop_empty: got v=%0b, want 0", ev_valid);
    else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    sb_on = 1'b1;
    popped = 0;
    for (int i = 0; i < 50; i++)
      make_event(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    ev_ready = 1'b1;
    for (int i = 0; i < 10 && ev_valid; i++) tick();
    sb_on = 1'b0;
    ev_ready = 1'b0;
    n_total++;
    if (popped != 50 || exp_q.size() != 0 || ev_valid !== 1'b0 || ovf !== 1'b0)
      $display("FAIL bp_count: got popped=%0d left=%0d v=%0b ovf=%0b, want 50 0 0 0",
               popped, exp_q.size(), ev_valid, ovf);
    else n_pass++;
  endtask

  task automatic test_wrap_hold1();
    rst2 = 1'b1; cmp2 = 1'b0; ev_ready2 = 1'b1;
    ts1 = 8'd1; ts2 = 8'd2;
    for (int i = 0; i < 14; i++) tick();
    cmp2 = 1'b1;
    tick();
    n_total++;
    if (ev_valid2 !== 1'b1 || ev_dir2 !== 1'b1 || ev_time2 !== 4'd14 || ev_diff2 !== 9'h1FF)
      $display("FAIL hold1_rise: got v=%0b d=%0b t=%0d diff=%h, want v=1 d=1 t=14 diff=1ff",
               ev_valid2, ev_dir2, ev_time2, ev_diff2);
    else n_pass++;
    cmp2 = 1'b0;
    tick();
    n_total++;
    if (ev_valid2 !== 1'b1 || ev_dir2 !== 1'b0 || ev_time2 !== 4'd15)
      $display("FAIL hold1_fall: got v=%0b d=%0b t=%0d, want v=1 d=0 t=15",
               ev_valid2, ev_dir2, ev_time2);
    else n_pass++;
    cmp2 = 1'b1;
    tick();
    n_total++;
    if (ev_valid2 !== 1'b1 || ev_dir2 !== 1'b1 || ev_time2 !== 4'd0 || ovf2 !== 1'b0)
      $display("FAIL wrap_time: got v=%0b d=%0b t=%0d ovf=%0b, want v=1 d=1 t=0 ovf=0",
               ev_valid2, ev_dir2, ev_time2, ovf2);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0; popped = 0; sb_on = 1'b0;
    t_now = 16'd0; t2 = 4'd0; lvl = 1'b0;
    rst = 1'b0; cmp_in = 1'b0; ev_ready = 1'b0; ts1 = 8'd0; ts2 = 8'd0;
    rst2 = 1'b0; cmp2 = 1'b0; ev_ready2 = 1'b0;
    test_reset();
    test_rise();
    test_fall();
    test_glitch();
    test_overflow();
    test_reset_midpend();
    test_full_pop();
    test_back_to_back();
    test_wrap_hold1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
